unidade_exec: RTL



---
 rtl/unidade_exec_pkg.sv | 20 ++
 rtl/unidade_exec_mul.sv | 45 ++++
 rtl/unidade_exec.sv | 135 +++++++++++++
 3 files changed

// File: rtl/unidade_exec_pkg.sv
// unidade_exec_pkg: opcodes, FSM states, error bit indices and defaults shared by the execution stage
package unidade_exec_pkg;
  localparam int ACC_W_DEF = 8;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_MUL = 4'hA;
  localparam logic [3:0] OP_CLR = 4'hB;
  localparam logic [3:0] OP_ILLEGAL = 4'hC;
  localparam int ERR_ILL = 0;
  localparam int ERR_OVR = 1;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
endpackage

// File: rtl/unidade_exec_mul.sv
// mul_serial: shift-add multiplier, one multiplier bit per run edge; prod/trunc show the value after the current step
module mul_serial #(
  parameter int AW = 8,
  parameter int BW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          run,
  input  logic [AW-1:0] a,
  input  logic [BW-1:0] b,
  output logic [AW-1:0] prod,
  output logic          trunc,
  output logic          done
);
  localparam int PW = AW + BW;
  localparam int KW = $clog2(BW + 1);
  localparam logic [KW-1:0] KLAST = KW'(BW - 1);
  logic [PW-1:0] p, mc, p_nxt;
  logic [BW-1:0] mb;
  logic [KW-1:0] k;
  assign p_nxt = p + (mb[0] ? mc : '0);
  assign prod = p_nxt[AW-1:0];
  assign trunc = |p_nxt[PW-1:AW];
  assign done = run && k == KLAST;
  // load operands on start, then accumulate one partial product per run edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p <= '0;
      mc <= '0;
      mb <= '0;
      k <= '0;
    end else if (start) begin
      p <= '0;
      mc <= PW'(a);
      mb <= b;
      k <= '0;
    end else if (run) begin
      p <= p_nxt;
      mc <= mc << 1;
      mb <= mb >> 1;
      k <= k + 1'b1;
    end
  end
endmodule

// File: rtl/unidade_exec.sv
// unidade_exec: accumulator execution stage; UNIDADE_EXEC_SAT_EN selects saturating ADD/SUB/MUL
module unidade_exec
  import unidade_exec_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int MUL_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Hab,
  input  logic             Fim_in,
  input  logic [3:0]       dados,
  input  logic [3:0]       oper,
  output logic [ACC_W-1:0] acc,
  output logic             flag_z,
  output logic             flag_c,
  output logic             Ocupado,
  output logic             Pronto,
  output logic [1:0]       Erro
);
`ifdef UNIDADE_EXEC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  state_t st;
  logic fim_d, rise, start, wa, c_nxt, fin, mul_last, mul_trunc;
  logic [3:0] op_q, dat_q;
  logic [2:0] cnt;
  logic [ACC_W-1:0] wr, sh_nxt, dat_x, res, mul_p;
  logic [ACC_W:0] sum, dif;
  assign rise = Fim_in & ~fim_d & Hab;
  assign start = rise && st == IDLE;
  assign dat_x = ACC_W'(dat_q);
  assign sum = {1'b0, acc} + {1'b0, dat_x};
  assign dif = {1'b0, acc} - {1'b0, dat_x};
  assign sh_nxt = cnt == 3'd0 ? wr : op_q == OP_SHL ? {wr[ACC_W-2:0], 1'b0} : {1'b0, wr[ACC_W-1:1]};
  assign fin = (op_q == OP_SHL || op_q == OP_SHR) ? cnt <= 3'd1 : op_q == OP_MUL ? mul_last : 1'b1;
  mul_serial #(.AW(ACC_W), .BW(MUL_BITS)) u_mul (
    .clk(clk),
    .rst(rst),
    .start(start),
    .run(st == EXEC && op_q == OP_MUL),
    .a(acc),
    .b(dados),
    .prod(mul_p),
    .trunc(mul_trunc),
    .done(mul_last)
  );
  // value and carry to commit when the current instruction finishes
  always_comb begin
    res = acc;
    c_nxt = flag_c;
    wa = 1'b1;
    case (op_q)
      OP_LOAD: res = dat_x;
      OP_ADD: begin
        res = SAT && sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        c_nxt = sum[ACC_W];
      end
      OP_SUB: begin
        res = SAT && dif[ACC_W] ? '0 : dif[ACC_W-1:0];
        c_nxt = dif[ACC_W];
      end
      OP_AND: res = acc & dat_x;
      OP_OR: res = acc | dat_x;
      OP_XOR: res = acc ^ dat_x;
      OP_NOT: res = ~acc;
      OP_SHL: begin
        res = sh_nxt;
        c_nxt = cnt != 3'd0 && wr[ACC_W-1];
      end
      OP_SHR: res = sh_nxt;
      OP_MUL: begin
        res = SAT && mul_trunc ? '1 : mul_p;
        c_nxt = mul_trunc;
      end
      OP_CLR: begin
        res = '0;
        c_nxt = 1'b0;
      end
      default: wa = 1'b0;
    endcase
  end
  // control FSM with registered status outputs; abort leaves acc/flags untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      fim_d <= 1'b0;
      op_q <= '0;
      dat_q <= '0;
      cnt <= '0;
      wr <= '0;
      acc <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      Ocupado <= 1'b0;
      Pronto <= 1'b0;
      Erro <= '0;
    end else begin
      fim_d <= Fim_in;
      Pronto <= 1'b0;
      if (rise && st != IDLE) Erro[ERR_OVR] <= 1'b1;
      case (st)
        IDLE: if (start) begin
          op_q <= oper;
          dat_q <= dados;
          cnt <= dados[2:0];
          wr <= acc;
          Ocupado <= 1'b1;
          st <= EXEC;
        end
        EXEC: if (!Hab) begin
          Ocupado <= 1'b0;
          st <= IDLE;
        end else begin
          wr <= sh_nxt;
          cnt <= cnt - 3'd1;
          if (fin) begin
            if (wa) begin
              acc <= res;
              flag_z <= res == '0;
            end
            flag_c <= c_nxt;
            if (op_q >= OP_ILLEGAL) Erro[ERR_ILL] <= 1'b1;
            Ocupado <= 1'b0;
            Pronto <= 1'b1;
            st <= DONE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
